alu_pipe_nbit: RTL and testbench

//  Parametrised, registered successor of the 4-bit combinational ALU: WIDTH-bit datapath, 16 opcodes, C/Z/N/V flags.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_pipe_nbit.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe_nbit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and FSM encoding for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_DEC   = 4'h7;
  localparam logic [3:0] OP_ADC   = 4'h8;
  localparam logic [3:0] OP_SBB   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_SAR   = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;
  localparam logic [3:0] OP_CMP   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH steps per product.
module alu_mul_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prod_next;

  // The final partial product is added combinationally so the product is ready on the WIDTH-th edge.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign o_done      = r_busy && (r_cnt == CW'(WIDTH-1));
  assign o_product   = w_prod_next;

  // Operand shift registers, running sum and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_prod   <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_prod   <= w_prod_next;
      r_cnt    <= r_cnt + CW'(1'b1);
      r_busy   <= !o_done;
    end else begin
      r_busy   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe_nbit.sv
// Registered WIDTH-bit ALU with valid/ready handshake, stored carry, accumulator feedback
// and a sequential multiply that blocks new requests while it runs.
module alu_pipe_nbit import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;

  logic [WIDTH-1:0]   w_a;
  logic               w_accept;
  logic               w_start;
  logic               w_load;
  logic               w_acc_load;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [WIDTH-1:0]   w_add_y;
  logic               w_add_cin;
  logic [WIDTH:0]     w_sum;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [WIDTH-1:0]   w_zn_src;
  logic [WIDTH-1:0]   w_fin_res;
  logic [3:0]         w_fin_flags;

  assign w_a        = use_acc ? r_acc : a;
  assign in_ready   = rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_start    = w_accept && (op == OP_MUL);
  assign w_load     = (w_accept && (op != OP_MUL)) || ((r_state == ST_MUL) && w_mul_done);
  assign w_acc_load = w_load && ((r_state == ST_MUL) || (op != OP_CMP));

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign busy      = (r_state == ST_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_a       (w_a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // All add/subtract-style ops share one WIDTH+1 adder; subtraction feeds ~b.
  always_comb begin
    w_add_y   = b;
    w_add_cin = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin w_add_y = ~b;               w_add_cin = 1'b1;    end
      OP_ADC:         begin w_add_y = b;                w_add_cin = r_carry; end
      OP_SBB:         begin w_add_y = ~b;               w_add_cin = r_carry; end
      OP_INC:         begin w_add_y = {WIDTH{1'b0}};    w_add_cin = 1'b1;    end
      OP_DEC:         begin w_add_y = {WIDTH{1'b1}};    w_add_cin = 1'b0;    end
      default:        begin w_add_y = b;                w_add_cin = 1'b0;    end
    endcase
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
  assign w_ovf = (w_a[WIDTH-1] == w_add_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  // Single-cycle opcode decode; CMP reports a but takes Z/N from the difference.
  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
        w_c = w_sum[WIDTH];
        w_v = w_ovf;
      end
      OP_AND:   w_res = w_a & b;
      OP_OR:    w_res = w_a | b;
      OP_XOR:   w_res = w_a ^ b;
      OP_NOT:   w_res = ~w_a;
      OP_SHL:   begin w_res = {w_a[WIDTH-2:0], 1'b0};        w_c = w_a[WIDTH-1]; end
      OP_SHR:   begin w_res = {1'b0, w_a[WIDTH-1:1]};        w_c = w_a[0];       end
      OP_SAR:   begin w_res = {w_a[WIDTH-1], w_a[WIDTH-1:1]}; w_c = w_a[0];      end
      OP_CMP:   begin w_res = w_a; w_c = w_sum[WIDTH]; w_v = w_ovf; end
      OP_PASSB: w_res = b;
      default:  w_res = w_sum[WIDTH-1:0];
    endcase
  end

  assign w_zn_src = (op == OP_CMP) ? w_sum[WIDTH-1:0] : w_res;

  // Select what loads into the output register: decoded op or finished product.
  always_comb begin
    w_fin_res   = w_res;
    w_fin_flags = 4'b0000;
    if (r_state == ST_MUL) begin
      w_fin_res        = w_mul_prod[WIDTH-1:0];
      w_fin_flags[F_C] = |w_mul_prod[2*WIDTH-1:WIDTH];
      w_fin_flags[F_Z] = (w_mul_prod[WIDTH-1:0] == {WIDTH{1'b0}});
      w_fin_flags[F_N] = w_mul_prod[WIDTH-1];
      w_fin_flags[F_V] = 1'b0;
    end else begin
      w_fin_res        = w_res;
      w_fin_flags[F_C] = w_c;
      w_fin_flags[F_Z] = (w_zn_src == {WIDTH{1'b0}});
      w_fin_flags[F_N] = w_zn_src[WIDTH-1];
      w_fin_flags[F_V] = w_v;
    end
  end

  // FSM plus output, accumulator and stored-carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_result    <= {WIDTH{1'b0}};
      r_flags     <= 4'b0000;
      r_out_valid <= 1'b0;
      r_acc       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_start ? ST_MUL : ST_IDLE;
        ST_MUL:  r_state <= w_mul_done ? ST_IDLE : ST_MUL;
        default: r_state <= ST_IDLE;
      endcase
      if (w_load) begin
        r_result    <= w_fin_res;
        r_flags     <= w_fin_flags;
        r_carry     <= w_fin_flags[F_C];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (w_acc_load) begin
        r_acc <= w_fin_res;
      end else begin
        r_acc <= r_acc;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Directed self-checking bench for alu_pipe_nbit at WIDTH=8.
module tb_alu_pipe_nbit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       use_acc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  alu_pipe_nbit #(.WIDTH(8), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one request for one edge, then drop in_valid (#1 after the edge).
  task automatic drive(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv, input logic ua);
    op = o; a = av; b = bv; use_acc = ua; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; use_acc = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    drive(4'h0, 8'hFF, 8'h01, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency out_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL add_result got=%h exp=00", result); end
    checks++; if (flags !== 4'b0011) begin failures++; $display("FAIL add_flags got=%b exp=0011", flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_adc();
    drive(4'h1, 8'h80, 8'h01, 1'b0);
    checks++; if (result !== 8'h7F) begin failures++; $display("FAIL sub_result got=%h exp=7f", result); end
    checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL sub_flags got=%b exp=1001", flags); end
    drive(4'h8, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL adc_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 8'h01) begin failures++; $display("FAIL adc_result got=%h exp=01", result); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL adc_flags got=%b exp=0000", flags); end
  endtask

  task automatic test_mul();
    drive(4'hD, 8'h10, 8'h11, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy cyc=%0d got=%b exp=1", k, busy); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mul_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_early_valid cyc=%0d got=%b exp=0", k, out_valid); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mul_valid got=%b exp=1", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_end got=%b exp=0", busy); end
    checks++; if (result !== 8'h10) begin failures++; $display("FAIL mul_result got=%h exp=10", result); end
    checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL mul_flags got=%b exp=0001", flags); end
  endtask

  task automatic test_stall();
    drive(4'h4, 8'hF0, 8'h3C, 1'b0);
    out_ready = 1'b0;
    op = 4'hF; a = 8'h00; b = 8'h55; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      @(posedge clk); #1;
      checks++; if (result !== 8'hCC || flags !== 4'b0100 || out_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold cyc=%0d got=%h/%b/%b exp=cc/0100/1", k, result, flags, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_resume_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result !== 8'h55 || flags !== 4'b0000) begin
      failures++; $display("FAIL stall_resume got=%h/%b exp=55/0000", result, flags);
    end
  endtask

  task automatic test_acc_cmp();
    drive(4'h0, 8'h05, 8'h03, 1'b0);
    drive(4'h6, 8'hAA, 8'h00, 1'b1);
    checks++; if (result !== 8'h09) begin failures++; $display("FAIL acc_inc got=%h exp=09", result); end
    drive(4'hE, 8'h09, 8'h09, 1'b0);
    checks++; if (result !== 8'h09 || flags !== 4'b0011) begin
      failures++; $display("FAIL cmp_eq got=%h/%b exp=09/0011", result, flags);
    end
    drive(4'hE, 8'h20, 8'h20, 1'b0);
    checks++; if (result !== 8'h20 || flags !== 4'b0011) begin
      failures++; $display("FAIL cmp_eq2 got=%h/%b exp=20/0011", result, flags);
    end
    drive(4'h6, 8'h00, 8'h00, 1'b1);
    checks++; if (result !== 8'h0A) begin failures++; $display("FAIL cmp_acc_kept got=%h exp=0a", result); end
  endtask

  task automatic test_back_to_back();
    vec_t vecs [12];
    vecs = '{
      '{4'hC, 8'h81, 8'h00, 8'hC0, 4'b0101},
      '{4'hA, 8'h81, 8'h00, 8'h02, 4'b0001},
      '{4'hB, 8'h81, 8'h00, 8'h40, 4'b0001},
      '{4'h7, 8'h00, 8'h00, 8'hFF, 4'b0100},
      '{4'h7, 8'h80, 8'h00, 8'h7F, 4'b1001},
      '{4'h5, 8'h0F, 8'h00, 8'hF0, 4'b0100},
      '{4'h2, 8'hF0, 8'h0F, 8'h00, 4'b0010},
      '{4'h3, 8'hA0, 8'h05, 8'hA5, 4'b0100},
      '{4'h6, 8'h7F, 8'h00, 8'h80, 4'b1100},
      '{4'h9, 8'h05, 8'h03, 8'h01, 4'b0001},
      '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100},
      '{4'h9, 8'h05, 8'h05, 8'hFF, 4'b0100}
    };
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      checks++; if (out_valid !== 1'b1 || result !== vecs[i].r || flags !== vecs[i].f) begin
        failures++;
        $display("FAIL b2b_vec%0d op=%h got=%b/%h/%b exp=1/%h/%b", i, vecs[i].op, out_valid, result, flags, vecs[i].r, vecs[i].f);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(4'hD, 8'h03, 8'h04, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 8'h00) begin
      failures++; $display("FAIL rst_mul got=%b/%b/%h exp=0/0/00", out_valid, busy, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'h0, 8'hEE, 8'h05, 1'b1);
    checks++; if (out_valid !== 1'b1 || result !== 8'h05) begin
      failures++; $display("FAIL rst_acc_cleared got=%b/%h exp=1/05", out_valid, result);
    end
    drive(4'hD, 8'h03, 8'h04, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h0C || flags !== 4'b0000) begin
      failures++; $display("FAIL rst_mul_again got=%b/%h/%b exp=1/0c/0000", out_valid, result, flags);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00; use_acc = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub_adc();
    test_mul();
    test_stall();
    test_acc_cmp();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
